// File: rtl/vc_writeback_buffer.sv
// Posted write buffer: queues evicted dirty lines and drains them in order to physical memory.
// Define VC_WB_FORWARD_EN to add the combinational line-forwarding lookup port.
module vc_writeback_buffer #(
  parameter int unsigned s_offset   = 5,
  parameter int unsigned s_line     = 256,
  parameter int unsigned addr_width = 32,
  parameter int unsigned depth      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_write,
  input  logic [addr_width-1:0] wb_address,
  input  logic [s_line-1:0]     wb_wdata,
  output logic                  wb_full,
  output logic                  wb_empty,
  output logic                  pmem_write,
  output logic [addr_width-1:0] pmem_address,
  output logic [s_line-1:0]     pmem_wdata,
  input  logic                  pmem_resp
`ifdef VC_WB_FORWARD_EN
  ,
  input  logic [addr_width-1:0] rd_address,
  output logic                  rd_hit,
  output logic [s_line-1:0]     rd_data
`endif
);

  localparam int unsigned idx_w = $clog2(depth);
  localparam int unsigned ptr_w = idx_w + 1;
  localparam int unsigned tag_w = addr_width - s_offset;

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  state_t             state;
  logic [ptr_w-1:0]   head;
  logic [ptr_w-1:0]   tail;
  logic [ptr_w-1:0]   count;
  logic [idx_w-1:0]   head_idx;
  logic [idx_w-1:0]   tail_idx;
  logic [tag_w-1:0]   tag_q  [depth];
  logic [s_line-1:0]  data_q [depth];
  logic [depth-1:0]   valid_q;
  logic               push;
  logic               pop;

  assign head_idx = head[idx_w-1:0];
  assign tail_idx = tail[idx_w-1:0];
  assign count    = tail - head;
  assign wb_full  = (count == ptr_w'(depth));
  assign wb_empty = (count == '0);
  assign push     = wb_write && !wb_full;
  assign pop      = (state == WRITE) && pmem_resp;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      valid_q <= '0;
    end else begin
      if (push) begin
        tail              <= tail + ptr_w'(1);
        valid_q[tail_idx] <= 1'b1;
      end
      if (pop) begin
        head              <= head + ptr_w'(1);
        valid_q[head_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_q[tail_idx]  <= wb_address[addr_width-1:s_offset];
      data_q[tail_idx] <= wb_wdata;
    end
  end

  // Request fields are captured on IDLE->WRITE so they stay stable while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!wb_empty) begin
            state        <= WRITE;
            pmem_write   <= 1'b1;
            pmem_address <= {tag_q[head_idx], {s_offset{1'b0}}};
            pmem_wdata   <= data_q[head_idx];
          end
        end
        WRITE: begin
          if (pmem_resp) begin
            state      <= IDLE;
            pmem_write <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

`ifdef VC_WB_FORWARD_EN
  logic [idx_w-1:0] fwd_idx;

  // Scan oldest to youngest so the youngest matching entry overrides earlier ones.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    fwd_idx = '0;
    for (int unsigned i = 0; i < depth; i++) begin
      fwd_idx = head_idx + idx_w'(i);
      if (valid_q[fwd_idx] && (tag_q[fwd_idx] == rd_address[addr_width-1:s_offset])) begin
        rd_hit  = 1'b1;
        rd_data = data_q[fwd_idx];
      end
    end
  end
`endif

endmodule

// File: tb/tb_vc_writeback_buffer.sv
// Self-checking bench for vc_writeback_buffer: table-driven vectors plus multi-cycle sequences.
module tb_vc_writeback_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wb_write = 1'b0;
  logic [31:0]  wb_address = '0;
  logic [255:0] wb_wdata = '0;
  logic         wb_full;
  logic         wb_empty;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp = 1'b0;
`ifdef VC_WB_FORWARD_EN
  logic [31:0]  rd_address = '0;
  logic         rd_hit;
  logic [255:0] rd_data;
`endif

  int checks = 0;
  int errors = 0;

  vc_writeback_buffer #(
    .s_offset  (5),
    .s_line    (256),
    .addr_width(32),
    .depth     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_write    (wb_write),
    .wb_address  (wb_address),
    .wb_wdata    (wb_wdata),
    .wb_full     (wb_full),
    .wb_empty    (wb_empty),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_resp   (pmem_resp)
`ifdef VC_WB_FORWARD_EN
    ,
    .rd_address  (rd_address),
    .rd_hit      (rd_hit),
    .rd_data     (rd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic         resp;
    logic         e_full;
    logic         e_empty;
    logic         e_pw;
    logic [31:0]  e_addr;
    logic [255:0] e_data;
  } vec_t;

  vec_t tbl[20];

  function automatic logic [255:0] pat(input int unsigned n);
    logic [31:0] w;
    w = (32'h0101_0101 * n) ^ 32'hC3A5_0F00;
    return {8{w}};
  endfunction

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [255:0] wdata,
                              input logic resp, input logic e_full, input logic e_empty,
                              input logic e_pw, input logic [31:0] e_addr, input logic [255:0] e_data);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.resp = resp;
    v.e_full = e_full; v.e_empty = e_empty; v.e_pw = e_pw;
    v.e_addr = e_addr; v.e_data = e_data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [31:0] oaddr[10];
  int pushed;
  int got;

  initial begin
    // Rows: values driven this cycle and outputs expected in the same cycle (before the edge).
    tbl[0]  = mk(1, 32'h0000_1234, pat(1), 0, 0, 1, 0, 32'h0, '0);
    tbl[1]  = mk(0, 32'h0,         '0,     0, 0, 0, 0, 32'h0, '0);
    tbl[2]  = mk(0, 32'h0,         '0,     0, 0, 0, 1, 32'h0000_1220, pat(1));
    tbl[3]  = mk(0, 32'h0,         '0,     1, 0, 0, 1, 32'h0000_1220, pat(1));
    tbl[4]  = mk(0, 32'h0,         '0,     0, 0, 1, 0, 32'h0, '0);
    tbl[5]  = mk(1, 32'h0000_2000, pat(2), 0, 0, 1, 0, 32'h0, '0);
    tbl[6]  = mk(1, 32'h0000_2020, pat(3), 0, 0, 0, 0, 32'h0, '0);
    tbl[7]  = mk(1, 32'h0000_2040, pat(4), 0, 0, 0, 1, 32'h0000_2000, pat(2));
    tbl[8]  = mk(1, 32'h0000_2060, pat(5), 0, 0, 0, 1, 32'h0000_2000, pat(2));
    tbl[9]  = mk(1, 32'hDEAD_0000, pat(6), 0, 1, 0, 1, 32'h0000_2000, pat(2));
    tbl[10] = mk(1, 32'h0000_3000, pat(7), 1, 1, 0, 1, 32'h0000_2000, pat(2));
    tbl[11] = mk(0, 32'h0,         '0,     0, 0, 0, 0, 32'h0, '0);
    tbl[12] = mk(0, 32'h0,         '0,     0, 0, 0, 1, 32'h0000_2020, pat(3));
    tbl[13] = mk(0, 32'h0,         '0,     1, 0, 0, 1, 32'h0000_2020, pat(3));
    tbl[14] = mk(0, 32'h0,         '0,     0, 0, 0, 0, 32'h0, '0);
    tbl[15] = mk(0, 32'h0,         '0,     1, 0, 0, 1, 32'h0000_2040, pat(4));
    tbl[16] = mk(0, 32'h0,         '0,     0, 0, 0, 0, 32'h0, '0);
    tbl[17] = mk(0, 32'h0,         '0,     1, 0, 0, 1, 32'h0000_2060, pat(5));
    tbl[18] = mk(0, 32'h0,         '0,     0, 0, 1, 0, 32'h0, '0);
    tbl[19] = mk(0, 32'h0,         '0,     0, 0, 1, 0, 32'h0, '0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_full",  wb_full,      1'b0);
    chk("reset_empty", wb_empty,     1'b1);
    chk("reset_pw",    pmem_write,   1'b0);
    chk("reset_addr",  pmem_address, 32'h0);
    chk("reset_data",  pmem_wdata,   256'h0);
`ifdef VC_WB_FORWARD_EN
    chk("reset_rd_hit",  rd_hit,  1'b0);
    chk("reset_rd_data", rd_data, 256'h0);
`endif

    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      wb_write   = tbl[i].wr;
      wb_address = tbl[i].addr;
      wb_wdata   = tbl[i].wdata;
      pmem_resp  = tbl[i].resp;
      #1;
      chk($sformatf("row%0d_full", i),  wb_full,    tbl[i].e_full);
      chk($sformatf("row%0d_empty", i), wb_empty,   tbl[i].e_empty);
      chk($sformatf("row%0d_pw", i),    pmem_write, tbl[i].e_pw);
      if (tbl[i].e_pw) begin
        chk($sformatf("row%0d_addr", i), pmem_address, tbl[i].e_addr);
        chk($sformatf("row%0d_data", i), pmem_wdata,   tbl[i].e_data);
      end
    end
    @(negedge clk);
    wb_write  = 1'b0;
    pmem_resp = 1'b0;

    // Ordering across pointer wrap with a memory that responds in the first WRITE cycle.
    for (int i = 0; i < 10; i++) oaddr[i] = 32'h4000 + 32'(i) * 32'h40 + 32'(i);
    pushed = 0;
    got = 0;
    for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
      @(negedge clk);
      pmem_resp = pmem_write;
      if (pmem_write) begin
        chk($sformatf("order%0d_addr", got), pmem_address, oaddr[got] & 32'hFFFF_FFE0);
        chk($sformatf("order%0d_data", got), pmem_wdata,   pat(20 + got));
        got++;
      end
      if (pushed < 10 && !wb_full) begin
        wb_write   = 1'b1;
        wb_address = oaddr[pushed];
        wb_wdata   = pat(20 + pushed);
        pushed++;
      end else begin
        wb_write = 1'b0;
      end
    end
    @(negedge clk);
    wb_write  = 1'b0;
    pmem_resp = 1'b0;
    #1;
    chk("order_count", got, 10);
    chk("order_empty", wb_empty, 1'b1);

`ifdef VC_WB_FORWARD_EN
    // Two pending writes to the same line: the younger one must be forwarded.
    @(negedge clk);
    wb_write   = 1'b1;
    wb_address = 32'h0000_0100;
    wb_wdata   = pat(40);
    rd_address = 32'h0000_011C;
    #1;
    chk("fwd_before_push", rd_hit, 1'b0);
    @(negedge clk);
    wb_wdata = pat(41);
    #1;
    chk("fwd_first_hit",  rd_hit,  1'b1);
    chk("fwd_first_data", rd_data, pat(40));
    @(negedge clk);
    wb_write = 1'b0;
    #1;
    chk("fwd_young_hit",  rd_hit,  1'b1);
    chk("fwd_young_data", rd_data, pat(41));
    rd_address = 32'h0000_0140;
    #1;
    chk("fwd_miss", rd_hit, 1'b0);
    rd_address = 32'h0000_011C;
    for (int cyc = 0; cyc < 50 && !wb_empty; cyc++) begin
      @(negedge clk);
      pmem_resp = pmem_write;
    end
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    chk("fwd_drained_empty", wb_empty, 1'b1);
    chk("fwd_drained_hit",   rd_hit,   1'b0);
`endif

    // Reset while a write is outstanding discards everything pending.
    @(negedge clk);
    wb_write   = 1'b1;
    wb_address = 32'h0000_5000;
    wb_wdata   = pat(30);
    @(negedge clk);
    wb_address = 32'h0000_5020;
    wb_wdata   = pat(31);
    @(negedge clk);
    wb_write = 1'b0;
    for (int k = 0; k < 10 && !pmem_write; k++) @(negedge clk);
    chk("rst_pre_pw", pmem_write, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_post_pw",    pmem_write, 1'b0);
    chk("rst_post_empty", wb_empty,   1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("rst_quiet%0d", k), pmem_write, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vc_writeback_buffer.md
# vc_writeback_buffer

Posted write buffer between the victim cache and physical memory. It accepts 256-bit dirty lines evicted from the victim cache, queues them in a small FIFO, and drains them one at a time to physical memory over a request/response handshake. This frees the victim cache from stalling on memory latency. Optionally, it forwards queued line data to a line read that hits a pending entry.

## Interface
- `s_offset`, 5, byte-offset bits per line
- `s_line`, 256, line width in bits (8·2^s_offset)
- `addr_width`, 32, address width
- `depth`, 4, number of FIFO entries; power of two, ≥2

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `wb_write`  in  1  push request from victim cache (dirty eviction)
- `wb_address`  in  addr_width  line address of the evicted line; low s_offset bits ignored
- `wb_wdata`  in  s_line  evicted line data
- `wb_full`  out  1  buffer full; a push is not accepted while high
- `wb_empty`  out  1  no pending entries
- `pmem_write`  out  1  memory write request
- `pmem_address`  out  addr_width  head entry address, low s_offset bits forced to 0
- `pmem_wdata`  out  s_line  head entry data
- `pmem_resp`  in  1  memory write complete (one-cycle pulse)
- `rd_address`  in  addr_width  forwarding lookup address (`VC_WB_FORWARD_EN` only)
- `rd_hit`  out  1  lookup matches a pending entry (`VC_WB_FORWARD_EN` only)
- `rd_data`  out  s_line  matched line data (`VC_WB_FORWARD_EN` only)

## Operation
- Storage: circular FIFO of {tag = address[addr_width-1:s_offset], data, valid}. Head/tail pointers are log2(depth)+1 bits wide and wrap modulo 2·depth. count = tail − head.
- wb_full = (count == depth) and wb_empty = (count == 0). Both are combinational from registered pointers.
- Push: wb_write && !wb_full writes the entry at tail and increments tail at the clock edge.
  - wb_write while full is dropped silently. The producer must hold the request until wb_full drops.
- No merging: a push whose line address equals a pending entry creates a new entry, and both are written to memory in order.
- Drain FSM, states IDLE and WRITE:
  - IDLE: if !wb_empty, go to WRITE next cycle; pmem_write=0.
  - WRITE: pmem_write=1; pmem_address/pmem_wdata are driven from head and held stable. On pmem_resp, pop head (head+1, valid cleared) and return to IDLE.
  - pmem_resp seen in IDLE is ignored.
- Simultaneous push and pop in one cycle: both take effect, and count is unchanged.
  - Full at cycle start: the push is rejected even if a pop occurs that cycle, because wb_full is evaluated pre-edge.
- An entry pushed in cycle N is eligible for drain no earlier than cycle N+2 (enters IDLE→WRITE check at N+1).

## Timing
- Reset values: wb_full=0, wb_empty=1, pmem_write=0, pmem_address=0, pmem_wdata=0, rd_hit=0, rd_data=0. Pointers are 0, all valid bits are 0, and the FSM is in IDLE.
- Reset during WRITE: pmem_write is 0 the cycle after the reset edge, and all pending entries are discarded.
- Minimum drain cost: one IDLE cycle plus WRITE cycles until pmem_resp. With a 1-cycle memory, back-to-back entries drain every 2 cycles.
- Forwarding lookup is combinational (same cycle):
  - It compares rd_address[addr_width-1:s_offset] against all valid entries.
  - On multiple matches, the youngest entry (closest to tail) wins.
  - An entry popped at an edge no longer hits after that edge. An entry pushed at an edge hits from the next cycle.

## Configuration
- `VC_WB_FORWARD_EN` defined: the rd_address/rd_hit/rd_data ports and the compare logic exist as described.
- Undefined: the three forwarding ports are absent and no compare logic is built. The FIFO/drain behaviour is identical.

## Test plan
- Reset, then a single push of addr 0x0000_1234 with data pattern A. Required: pmem_write rises 2 cycles after the push with pmem_address=0x0000_1220 and data A. After pmem_resp, wb_empty=1 the next cycle.
- Fill: 4 pushes with pmem_resp held low. Required: wb_full=1 after the 4th. A 5th push of 0xDEAD0000 is dropped and never appears on pmem_address.
- Full plus pop in the same cycle: with 4 entries, pulse pmem_resp while wb_write is high. Required: the push is rejected, count=3, and wb_full=0 the next cycle.
- Ordering with wrap: push 10 distinct lines with 1-cycle memory responses. Required: pmem_address sequence equals the push order exactly, with no lost or duplicated entries.
- Forwarding (`VC_WB_FORWARD_EN`): push 0x100 with data A, then 0x100 with data B, then look up 0x11C. Required: rd_hit=1 and rd_data=B. After both drain, rd_hit=0.
- Reset mid-WRITE: with 2 entries pending and pmem_write=1, assert rst for one cycle. Required: pmem_write=0 and wb_empty=1 the next cycle, and no further memory requests occur.
